text_cursor_scheduler: RTL

Sits between keyboard_decoder and the glyph-plot datapath/control_FSM pair. Accepts ASCII characters and maintains a text cursor on a character grid. It converts the cursor into pixel coordinates and issues one glyph-draw job at a time to the plotter. It also sequences the multi-glyph jobs: erasing on backspace, clearing a row on newline, and clearing the whole screen.

---
 rtl/text_cursor_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/text_cursor_scheduler.sv
// Text cursor scheduler: turns ASCII keystrokes into single-glyph plot jobs,
// tracks the cursor and sequences backspace erase, row fill and screen clear.
module text_cursor_scheduler #(
  parameter int         COLS    = 40,
  parameter int         ROWS    = 15,
  parameter int         GLYPH_W = 8,
  parameter int         GLYPH_H = 16,
  parameter logic [6:0] SPACE   = 7'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       char_valid,
  input  logic [6:0] char_code,
  output logic       char_ready,
  input  logic       clear_req,
  output logic       draw_start,
  output logic [8:0] draw_x,
  output logic [9:0] draw_y,
  output logic [6:0] draw_char,
  input  logic       draw_done,
  output logic [5:0] cursor_col,
  output logic [3:0] cursor_row,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_FILL_NEXT = 3'd4;

  localparam logic [1:0] P_NONE   = 2'd0;
  localparam logic [1:0] P_ADV    = 2'd1;
  localparam logic [1:0] P_ROW    = 2'd2;
  localparam logic [1:0] P_SCREEN = 2'd3;

  localparam logic [5:0] COL_MAX = 6'(COLS - 1);
  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

  logic [2:0] state;
  logic [1:0] post;
  logic [6:0] code_q;
  logic [5:0] fill_col;
  logic [3:0] fill_row;

  logic [3:0] nl_row;
  logic [5:0] bs_col;
  logic [3:0] bs_row;
  logic [5:0] fn_col;
  logic [3:0] fn_row;

  function automatic logic [8:0] px_x(input logic [5:0] c);
    return 9'(c) * 9'(GLYPH_W);
  endfunction

  function automatic logic [9:0] px_y(input logic [3:0] r);
    return 10'(r) * 10'(GLYPH_H);
  endfunction

  assign char_ready = reset_n && (state == S_IDLE) && !clear_req;
  assign draw_start = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);

  always_comb begin
    nl_row = (cursor_row == ROW_MAX) ? 4'd0 : cursor_row + 4'd1;
    bs_col = cursor_col;
    bs_row = cursor_row;
    if (cursor_col != 6'd0) begin
      bs_col = cursor_col - 6'd1;
    end else if (cursor_row != 4'd0) begin
      bs_col = COL_MAX;
      bs_row = cursor_row - 4'd1;
    end
    // Fill stepping walks row-major and wraps the row at the bottom.
    fn_col = fill_col + 6'd1;
    fn_row = fill_row;
    if (fill_col == COL_MAX) begin
      fn_col = 6'd0;
      fn_row = (fill_row == ROW_MAX) ? 4'd0 : fill_row + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      post       <= P_NONE;
      code_q     <= 7'd0;
      fill_col   <= 6'd0;
      fill_row   <= 4'd0;
      cursor_col <= 6'd0;
      cursor_row <= 4'd0;
      draw_x     <= 9'd0;
      draw_y     <= 10'd0;
      draw_char  <= 7'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            fill_row  <= 4'd0;
            fill_col  <= 6'd0;
            draw_x    <= 9'd0;
            draw_y    <= 10'd0;
            draw_char <= SPACE;
            post      <= P_SCREEN;
            state     <= S_ISSUE;
          end else if (char_valid) begin
            code_q <= char_code;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (code_q >= 7'h20 && code_q <= 7'h7E) begin
            draw_x    <= px_x(cursor_col);
            draw_y    <= px_y(cursor_row);
            draw_char <= code_q;
            post      <= P_ADV;
            state     <= S_ISSUE;
          end else if (code_q == 7'h0A || code_q == 7'h0D) begin
            cursor_col <= 6'd0;
            cursor_row <= nl_row;
            fill_row   <= nl_row;
            fill_col   <= 6'd0;
            draw_x     <= 9'd0;
            draw_y     <= px_y(nl_row);
            draw_char  <= SPACE;
            post       <= P_ROW;
            state      <= S_ISSUE;
          end else if (code_q == 7'h08) begin
            cursor_col <= bs_col;
            cursor_row <= bs_row;
            draw_x     <= px_x(bs_col);
            draw_y     <= px_y(bs_row);
            draw_char  <= SPACE;
            post       <= P_NONE;
            state      <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (draw_done) begin
            case (post)
              P_ADV: begin
                if (cursor_col == COL_MAX) begin
                  // Seed the fill at the old row's last column so the first
                  // FILL_NEXT step lands on (new row, 0).
                  cursor_col <= 6'd0;
                  cursor_row <= nl_row;
                  fill_row   <= cursor_row;
                  fill_col   <= COL_MAX;
                  post       <= P_ROW;
                  state      <= S_FILL_NEXT;
                end else begin
                  cursor_col <= cursor_col + 6'd1;
                  state      <= S_IDLE;
                end
              end
              P_ROW, P_SCREEN: begin
                if (fill_col == COL_MAX && (post == P_ROW || fill_row == ROW_MAX)) begin
                  if (post == P_SCREEN) begin
                    cursor_col <= 6'd0;
                    cursor_row <= 4'd0;
                  end
                  state <= S_IDLE;
                end else begin
                  state <= S_FILL_NEXT;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_FILL_NEXT: begin
          fill_col  <= fn_col;
          fill_row  <= fn_row;
          draw_x    <= px_x(fn_col);
          draw_y    <= px_y(fn_row);
          draw_char <= SPACE;
          state     <= S_ISSUE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
